trap_cfg_ctrl: RTL

TRAP_CFG_CTRL -- requirements
Module: trap_cfg_ctrl

---
 rtl/trap_ctrl_pkg.sv | 19 +
 rtl/settle_timer.sv | 34 +++
 rtl/trap_cfg_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trapezoidal-filter configuration controller.
//   DLY_W   : width of the Kdelay / Ldelay fields
//   MULT_W  : width of the signed decay factor
//   CNT_W   : width of the hold/settle down-counter
//   ctrl_state_e : controller FSM state encoding
package trap_ctrl_pkg;

  localparam int DLY_W  = 14;
  localparam int MULT_W = 16;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter shared by the HOLD and SETTLE phases.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears the count
//   load     : load load_val (takes priority over count)
//   load_val : value loaded; the phase lasts load_val+1 cycles
//   count    : decrement enable, saturates at zero
//   done     : count has reached zero
module settle_timer
  import trap_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             count,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/trap_cfg_ctrl.sv
// Configuration controller for a trapezoidal filter. Accepts a new
// Kdelay/Ldelay/mult set, holds the filter in reset, waits for its pipeline
// to fill plus a guard interval, then flags the output as trustworthy.
// Ports:
//   clk, areset        : clock, asynchronous active-high reset
//   cfg_kdelay/ldelay  : requested rise/fall length and L delay
//   cfg_mult           : requested signed decay factor
//   cfg_valid/ready    : configuration handshake
//   cfg_error          : one-cycle pulse after a rejected request
//   filt_aresetn       : active-low reset to the filter
//   filt_kdelay/ldelay/mult : applied configuration
//   s_axis_tvalid      : filter output valid
//   m_axis_tvalid      : filter valid gated by running
//   running            : filter has settled
module trap_cfg_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES  = 4,
  parameter int GUARD_CYCLES = 8,
  parameter int KMIN         = 3
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic [DLY_W-1:0]         cfg_kdelay,
  input  logic [DLY_W-1:0]         cfg_ldelay,
  input  logic signed [MULT_W-1:0] cfg_mult,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic                     cfg_error,
  output logic                     filt_aresetn,
  output logic [DLY_W-1:0]         filt_kdelay,
  output logic [DLY_W-1:0]         filt_ldelay,
  output logic signed [MULT_W-1:0] filt_mult,
  input  logic                     s_axis_tvalid,
  output logic                     m_axis_tvalid,
  output logic                     running
);

  // Timer reload values are "length - 1" because done is seen in the last cycle.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_V   = CNT_W'(GUARD_CYCLES);
  localparam logic [DLY_W-1:0] KMIN_V    = DLY_W'(KMIN);

  ctrl_state_e      state, state_nxt;
  logic             alive;
  logic             hs, legal, accept, reject;
  logic             tmr_load, tmr_count, tmr_done;
  logic [CNT_W-1:0] tmr_val, settle_load;

  assign hs    = cfg_valid & cfg_ready;
  assign legal = (cfg_kdelay >= KMIN_V) && (cfg_ldelay >= cfg_kdelay);

  // K+L+1+GUARD cycles of settle, so the reload is K+L+GUARD; never underflows.
  assign settle_load = CNT_W'({1'b0, filt_kdelay} + {1'b0, filt_ldelay}) + GUARD_V;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = HOLD_LOAD;
    tmr_count = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (hs) begin
          if (legal) begin
            accept    = 1'b1;
            tmr_load  = 1'b1;
            state_nxt = HOLD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      HOLD: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_val   = settle_load;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        tmr_count = 1'b1;
        if (tmr_done) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cfg_error   <= 1'b0;
      filt_kdelay <= '0;
      filt_ldelay <= '0;
      filt_mult   <= '0;
    end else begin
      cfg_error <= reject;
      if (accept) begin
        filt_kdelay <= cfg_kdelay;
        filt_ldelay <= cfg_ldelay;
        filt_mult   <= cfg_mult;
      end
    end
  end

  settle_timer u_timer (
    .clk      (clk),
    .rst      (areset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  // alive keeps cfg_ready low until the first edge after reset release.
  assign cfg_ready     = alive & ((state == IDLE) | (state == RUN));
  assign filt_aresetn  = (state == SETTLE) | (state == RUN);
  assign running       = (state == RUN);
  assign m_axis_tvalid = s_axis_tvalid & running;

endmodule
